rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ independent requesters, e.g. ALU writeback, load unit and link-register write.
- Round-robin arbitration with a valid/ready handshake per requester.
- The selected write is registered and driven onto the register file's write_data_in / write_register_in / regWrite_in inputs.
- Sits between the datapath writeback sources and register_file, and owns the only path to its write port.

Parameters:
- DATA_WIDTH, 16, width of a register word.
- ADDRESS_WIDTH, 5, register index width (32 registers).
- NUM_REQ, 3, number of requesters; legal range 2..4.
- COUNT_WIDTH, 16, width of the saturating contention counter.

Ports:
- clock_in  input  1  single clock; all state updates on posedge.
- reset_in  input  1  synchronous, active-high reset.
- hold_in  input  1  when 1, no grant is issued this cycle.
- req_valid_in  input  NUM_REQ  bit i: requester i presents a write.
- req_register_in  input  NUM_REQ*ADDRESS_WIDTH  slice i = destination register of requester i.
- req_data_in  input  NUM_REQ*DATA_WIDTH  slice i = write data of requester i.
- req_ready_out  output  NUM_REQ  one-hot or zero, combinational grant; bit i=1 means requester i's write is accepted this cycle.
- write_data_out  output  DATA_WIDTH  registered write data to register_file.
- write_register_out  output  ADDRESS_WIDTH  registered destination to register_file.
- regWrite_out  output  1  registered write enable to register_file.
- grant_out  output  NUM_REQ  registered one-hot copy of last cycle's req_ready_out.
- conflict_count_out  output  COUNT_WIDTH  saturating count of cycles with two or more valid requests.

Behaviour:
- Reset (reset_in=1 at posedge) clears all registered state:
  - regWrite_out=0, write_data_out=0, write_register_out=0, grant_out=0, conflict_count_out=0, priority pointer=0.
  - While reset_in=1, req_ready_out=0.
- Handshake:
  - A transfer occurs for requester i in a cycle where req_valid_in[i]=1 and req_ready_out[i]=1.
  - Requesters must hold valid, register and data stable until accepted; the arbiter does not check this.
- Grant selection (combinational):
  - No grant if hold_in=1, reset_in=1, or no valid request.
  - Otherwise grant the first valid requester found scanning from pointer upward, wrapping modulo NUM_REQ.
  - At most one req_ready_out bit is high.
- Pointer: on a transfer by requester g, pointer <= (g+1) mod NUM_REQ at posedge. No transfer leaves the pointer unchanged, including during hold_in.
- Output stage, 1-cycle latency:
  - On a transfer at posedge k: write_data_out/write_register_out latch the granted slice, regWrite_out=1, and grant_out=req_ready_out during cycle k+1.
  - register_file commits at posedge k+1.
  - A cycle with no transfer gives regWrite_out=0 next cycle; data and register outputs hold their last values.
  - Back-to-back transfers give regWrite_out high continuously, one write per cycle; full throughput.
- conflict_count_out: increments at each posedge where popcount(req_valid_in)>=2, regardless of hold_in. It saturates at all-ones and never wraps.
- Same destination from two requesters: serialized in grant order, so the later grant wins in the register file. No merging.
- Reset mid-operation: a write latched in the output stage is dropped (regWrite_out forced 0 next cycle). Requests not yet accepted must be re-presented.
- hold_in asserted while requests pending: req_ready_out=0, and regWrite_out=0 from the next cycle. On release, arbitration resumes from the unchanged pointer.

Optional Feature:
- Macro: RF_WRITE_ARBITER_DROP_ZERO_EN.
- Defined: a transfer whose destination is register 0 is still accepted (ready, pointer advance, grant_out set), but regWrite_out stays 0 for it. This keeps register 0 hardwired to zero at the port.
- Undefined: register-0 writes are forwarded like any other, with regWrite_out=1.

Test Plan:
- Reset then idle: hold reset_in=1 for 2 cycles, then all valid=0 -> all outputs 0, req_ready_out=0, conflict_count_out=0.
- Single requester: req 1 valid, reg 5'd30, data 16'h0005 -> req_ready_out=3'b010 same cycle; next cycle regWrite_out=1, write_register_out=30, write_data_out=16'h0005, grant_out=3'b010; register_file x30 reads 16'h0005 afterwards.
- Round-robin fairness: all three valid continuously (regs 1/15/16, data 16'h0001/16'hffff/16'hfffb), pointer=0 -> grants in order 0,1,2,0,..., one per cycle; conflict_count_out increments each cycle.
- Hold: req 0 and req 2 valid, hold_in=1 for 3 cycles -> no ready, regWrite_out=0, pointer unchanged. Release -> req 0 granted first, then req 2.
- Register 0 write, data 16'h0ff0: with RF_WRITE_ARBITER_DROP_ZERO_EN defined -> ready=1 and regWrite_out=0. Undefined -> regWrite_out=1, write_register_out=0. Either way register_file x0 reads 16'h0000.
- Reset mid-transfer, 16'hf00f to x31: reset_in=1 in the cycle after acceptance -> regWrite_out=0, pointer=0, conflict_count_out=0, and x31 is not written.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Round-robin arbiter that shares the register file's single write port among
// NUM_REQ requesters (e.g. ALU writeback, load unit, link-register write).
// The granted write is registered and presented to register_file one cycle
// after acceptance.
//
// Optional feature (compile-time macro RF_WRITE_ARBITER_DROP_ZERO_EN):
//   defined   -> writes to register 0 are accepted but never raise regWrite_out
//   undefined -> writes to register 0 are forwarded like any other
//
// Ports:
//   clock_in            clock, all state updates on posedge
//   reset_in            synchronous active-high reset
//   hold_in             suppresses all grants this cycle
//   req_valid_in        per-requester write valid
//   req_register_in     per-requester destination register (packed slices)
//   req_data_in         per-requester write data (packed slices)
//   req_ready_out       combinational one-hot (or zero) grant
//   write_data_out      registered write data to register_file
//   write_register_out  registered destination to register_file
//   regWrite_out        registered write enable to register_file
//   grant_out           registered copy of last cycle's req_ready_out
//   conflict_count_out  saturating count of cycles with >= 2 valid requests

module rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                             clock_in,
  input  logic                             reset_in,
  input  logic                             hold_in,
  input  logic [NUM_REQ-1:0]               req_valid_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_register_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_in,
  output logic [NUM_REQ-1:0]               req_ready_out,
  output logic [DATA_WIDTH-1:0]            write_data_out,
  output logic [ADDRESS_WIDTH-1:0]         write_register_out,
  output logic                             regWrite_out,
  output logic [NUM_REQ-1:0]               grant_out,
  output logic [COUNT_WIDTH-1:0]           conflict_count_out
);

  // NUM_REQ is limited to 2..4, so the pointer never needs more than 2 bits.
  localparam int unsigned PtrWidth = (NUM_REQ > 2) ? 2 : 1;

  logic [PtrWidth-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] reg_q, reg_d;
  logic                     wen_q, wen_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;

  logic [NUM_REQ-1:0]       grant;
  logic [PtrWidth-1:0]      gnt_idx;
  logic                     found;
  logic                     transfer;
  int unsigned              scan_idx;
  int unsigned              valid_cnt;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [ADDRESS_WIDTH-1:0] sel_reg;

  // Grant: first valid requester scanning upward from the pointer, wrapping.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (!reset_in && !hold_in) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = {{(32 - PtrWidth){1'b0}}, ptr_q} + k;
        if (scan_idx >= NUM_REQ) begin
          scan_idx = scan_idx - NUM_REQ;
        end
        if (!found && req_valid_in[scan_idx]) begin
          found         = 1'b1;
          gnt_idx       = scan_idx[PtrWidth-1:0];
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign transfer      = |grant;
  assign req_ready_out = grant;

  // One-hot AND-OR mux of the granted slice.
  always_comb begin
    sel_data = '0;
    sel_reg  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_reg  = sel_reg | req_register_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  always_comb begin
    valid_cnt = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      valid_cnt = valid_cnt + 32'(req_valid_in[i]);
    end
  end

  // Next-state for pointer, output stage and contention counter.
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    reg_d   = reg_q;
    wen_d   = 1'b0;
    grant_d = grant;
    count_d = count_q;

    if (transfer) begin
      ptr_d  = (gnt_idx == PtrWidth'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      data_d = sel_data;
      reg_d  = sel_reg;
`ifdef RF_WRITE_ARBITER_DROP_ZERO_EN
      // Keep register 0 hardwired to zero at the port.
      wen_d  = (sel_reg != '0);
`else
      wen_d  = 1'b1;
`endif
    end

    if (valid_cnt >= 2 && count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      ptr_q   <= '0;
      data_q  <= '0;
      reg_q   <= '0;
      wen_q   <= 1'b0;
      grant_q <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      reg_q   <= reg_d;
      wen_q   <= wen_d;
      grant_q <= grant_d;
      count_q <= count_d;
    end
  end

  // A write already in the output stage is dropped if reset arrives before
  // register_file commits it, so the enable is masked by reset_in.
  assign regWrite_out       = wen_q & ~reset_in;
  assign write_data_out     = data_q;
  assign write_register_out = reg_q;
  assign grant_out          = grant_q;
  assign conflict_count_out = count_q;

endmodule
